// File: rtl/decoder3e_pkg.sv
// Shared widths and types for the registered 3-to-8 one-hot decoder.
package decoder3e_pkg;

    localparam int DEC_SEL_W = 3;
    localparam int DEC_OUT_W = 1 << DEC_SEL_W;

    typedef logic [DEC_SEL_W-1:0] dec_sel_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage : decoder3e_pkg

// File: rtl/decoder3e.sv
// Registered N-to-2**N one-hot decoder with enable.
// Define DECODER3E_VALID_EN to add a `valid` output registered from `ena`.
module decoder3e
    import decoder3e_pkg::*;
#(
    parameter int N = DEC_SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        n,
    input  logic                ena,
`ifdef DECODER3E_VALID_EN
    output logic                valid,
`endif
    output logic [(1<<N)-1:0]   e
);

    localparam int OUT_W = 1 << N;

    logic [OUT_W-1:0] dec;

    // Gating each compare with ena keeps the next value zero even if n is X.
    for (genvar i = 0; i < OUT_W; i++) begin : g_dec
        assign dec[i] = ena && (n == i);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // pre-edge values; the reset is synchronous, checked first.
        if (rst) begin
            e <= '0;
        end else begin
            e <= dec;
        end
    end

`ifdef DECODER3E_VALID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else begin
            valid <= ena;
        end
    end
`endif

endmodule : decoder3e

// File: tb/tb_decoder3e.sv
// Self-checking bench for decoder3e: table-driven vectors through a scoreboard queue.
module tb_decoder3e;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] n;
    logic       ena;
    logic [7:0] e;
`ifdef DECODER3E_VALID_EN
    logic       valid;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       ena;
        logic [2:0] n;
        logic [7:0] exp_e;
        logic       exp_valid;
    } vec_t;

    typedef struct {
        logic [7:0] exp_e;
        logic       exp_valid;
        string      name;
    } sb_t;

    sb_t sb_q[$];

    decoder3e dut (
        .clk   (clk),
        .rst   (rst),
        .n     (n),
        .ena   (ena),
`ifdef DECODER3E_VALID_EN
        .valid (valid),
`endif
        .e     (e)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Output must be one-hot or zero on every cycle.
    always @(negedge clk) begin
        if (!$onehot0(e)) begin
            errors++;
            $display("FAIL onehot0: e=%b, required at most one bit set", e);
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input logic r, input logic en, input logic [2:0] sel,
                        input logic [7:0] exp_e, input logic exp_v, input string name);
        sb_t s;
        rst = r;
        ena = en;
        n   = sel;
        sb_q.push_back('{exp_e: exp_e, exp_valid: exp_v, name: name});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, required one entry", name);
        end else begin
            s = sb_q.pop_front();
            check(s.name, e, s.exp_e);
`ifdef DECODER3E_VALID_EN
            check({s.name, "_valid"}, {7'd0, valid}, {7'd0, s.exp_valid});
`endif
        end
    endtask

    vec_t vecs[$];

    initial begin
        // Reset held two cycles with ena=1, n=5, then release.
        vecs.push_back('{1'b1, 1'b1, 3'd5, 8'b00000000, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 8'b00000000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 8'b00100000, 1'b1});
        // Full sweep 0..7.
        vecs.push_back('{1'b0, 1'b1, 3'd0, 8'b00000001, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 8'b00000010, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd2, 8'b00000100, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 8'b00001000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 8'b00010000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 8'b00100000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 8'b01000000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 8'b10000000, 1'b1});
        // Disable with n=7, then re-enable at n=0.
        vecs.push_back('{1'b0, 1'b0, 3'd7, 8'b00000000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 8'b00000001, 1'b1});
        // Simultaneous n 3->6 and ena 0->1.
        vecs.push_back('{1'b0, 1'b0, 3'd3, 8'b00000000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 8'b01000000, 1'b1});

        rst = 1'b1;
        ena = 1'b0;
        n   = 3'd0;

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].n, vecs[i].exp_e, vecs[i].exp_valid,
                 $sformatf("vec%0d", i));
        end

        // Mid-stream reset while sweeping at n=4; decode resumes from the current n.
        step(1'b0, 1'b1, 3'd2, 8'b00000100, 1'b1, "mid_n2");
        step(1'b0, 1'b1, 3'd3, 8'b00001000, 1'b1, "mid_n3");
        step(1'b1, 1'b1, 3'd4, 8'b00000000, 1'b0, "mid_rst");
        step(1'b0, 1'b1, 3'd4, 8'b00010000, 1'b1, "mid_resume");
        step(1'b0, 1'b1, 3'd5, 8'b00100000, 1'b1, "mid_n5");

        // ena toggles 1->0->1 on consecutive cycles.
        step(1'b0, 1'b1, 3'd1, 8'b00000010, 1'b1, "tog_on1");
        step(1'b0, 1'b0, 3'd1, 8'b00000000, 1'b0, "tog_off");
        step(1'b0, 1'b1, 3'd1, 8'b00000010, 1'b1, "tog_on2");

        // Unknown select while disabled must still give zero.
        step(1'b0, 1'b0, 3'bxxx, 8'b00000000, 1'b0, "dis_nx");
        step(1'b0, 1'b1, 3'd7, 8'b10000000, 1'b1, "after_nx");

        // Randomised stretch checked against a simple reference model.
        for (int k = 0; k < 40; k++) begin
            logic       r;
            logic       en;
            logic [2:0] sel;
            logic [7:0] exp_e;
            r     = ($urandom_range(0, 9) == 0);
            en    = $urandom_range(0, 1) == 1;
            sel   = 3'($urandom_range(0, 7));
            exp_e = (!r && en) ? (8'b1 << sel) : 8'b0;
            step(r, en, sel, exp_e, !r && en, $sformatf("rnd%0d", k));
        end

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_decoder3e
